wb_write_queue: RTL and testbench
=================================

Name: wb_write_queue

Overview:
- Writeback-side producer for the 8-entry, 3-bit-addressed register file.
- Buffers register write requests from execute/memory stages in a small in-order queue.
- Drains at most one entry per cycle onto the register file write port (we/addr_w/data).
- Supplies read-after-write forwarding for both operand read ports while writes are still pending.

Parameters:
D_BITS, 32, data width; matches register file data width.
DEPTH, 4, queue entries; power of two, >= 2.

Ports:
clk  input  1  clock, all state on rising edge
nrst  input  1  synchronous active-low reset
in_valid  input  1  producer has a write request
in_ready  output  1  queue can accept request this cycle
in_addr  input  3  destination register index
in_data  input  D_BITS  write data
drain_en  input  1  register file write port available this cycle
rf_we  output  1  to register file we
rf_addr_w  output  3  to register file addr_w
rf_data  output  D_BITS  to register file data
fwd_src_op0  input  3  same index as register file src_op0
fwd_src_op1  input  3  same index as register file src_op1
fwd_hit0  output  1  pending write exists for fwd_src_op0
fwd_data0  output  D_BITS  newest pending data for fwd_src_op0
fwd_hit1  output  1  pending write exists for fwd_src_op1
fwd_data1  output  D_BITS  newest pending data for fwd_src_op1
count  output  $clog2(DEPTH)+1  occupied entries

Behaviour:
- Reset: clock is clk; reset is synchronous, active-low on nrst.
  - On a rising edge with nrst=0: count=0, head/tail pointers=0, all entries invalid.
  - While nrst=0: in_ready=0, rf_we=0, fwd_hit0/1=0.
  - Reset mid-operation discards all pending writes; nothing is written to the register file.
- Push: accept when in_valid && in_ready. Entry stored at tail, tail increments mod DEPTH.
- in_ready = nrst && (count < DEPTH). It is combinational from count and does not look ahead at a same-cycle pop, so a full queue refuses the request even if it drains that cycle.
- Pop: rf_we = drain_en && count!=0. Outputs are combinational from the head entry.
  - rf_addr_w/rf_data = head entry when count!=0, else 0.
  - On the edge where rf_we=1, the register file captures the write and head increments mod DEPTH.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Latency: a request accepted at edge N sits at head no earlier than after edge N. Earliest register file update is edge N+1, i.e. one cycle of buffering minimum.
- Order: strictly FIFO. Multiple writes to the same index retire in acceptance order.
- Register 0 is an ordinary register; writes to index 0 are queued and forwarded like any other.
- Forwarding (combinational):
  - Scan valid entries and select the newest (closest to tail) with addr == fwd_src_opX.
  - The head entry being popped this cycle still counts as a hit, because the register file does not yet hold it.
  - The in_* request arriving this cycle is not considered.
  - No match: fwd_hitX=0, fwd_dataX=0.
- Pointer wrap: pointers are $clog2(DEPTH) bits and wrap naturally. Full/empty are determined by count only.

Optional Feature:
- Macro WB_COALESCE_EN.
  - Defined: an accepted request whose in_addr equals the newest valid entry's addr overwrites that entry's data; count and tail are unchanged. Exception: if that entry is the head and is being popped this cycle, allocate normally. In this mode in_ready also rises when full and a coalesce hit exists.
  - Undefined: every accepted request allocates a new entry.

Decomposition:
- Package wb_pkg:
  - REG_ADDR_W=3, NUM_REGS=8.
  - Typedef wb_entry_t {addr[2:0], data[D_BITS-1:0]}.
- One sub-module, wb_fwd_match: priority compare of one source index against all entries plus the head/count window, returning hit and data. Instantiated twice, once per operand port.

Test Plan:
- Reset then idle: nrst=0 for 2 edges, release → count=0, in_ready=1, rf_we=0, fwd_hit0=fwd_hit1=0.
- Single write: push addr=3 data=0xDEADBEEF with drain_en=0 → next cycle count=1, fwd_src_op0=3 gives hit0=1, data0=0xDEADBEEF. Raise drain_en → rf_we=1, rf_addr_w=3 for exactly one cycle, then count=0.
- Fill and refuse: drain_en=0, push addrs 1,2,3,4 → count=4, in_ready=0. A fifth request (addr 5) is not accepted. Enable drain → writes retire in order 1,2,3,4 on consecutive edges.
- Newest-wins forwarding: push addr=2 data=0x11, then addr=2 data=0x22, no drain → fwd_data1=0x22. After one pop → still 0x22. After the second pop → hit1=0.
- Concurrent push/pop at count=2 → count stays 2 and order is preserved across pointer wrap (push 10 requests total, DEPTH=4).
- Reset mid-stream: count=3, assert nrst=0 for one edge → count=0, rf_we=0, no pending data written afterwards. With WB_COALESCE_EN, back-to-back addr=6 data=0xA then 0xB → count=1, drained data=0xB.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback write queue.
package wb_pkg;

  localparam int unsigned REG_ADDR_W = 3;
  localparam int unsigned NUM_REGS   = 8;
  localparam int unsigned WB_D_BITS  = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [WB_D_BITS-1:0]  data;
  } wb_entry_t;

endpackage

// File: rtl/wb_write_queue_fwd_match.sv
// Newest-match search of one source index over the occupied queue window.
module wb_fwd_match
  import wb_pkg::*;
#(
  parameter int unsigned D_BITS = 32,
  parameter int unsigned DEPTH  = 4
) (
  input  logic [REG_ADDR_W-1:0]      src_i,
  input  logic [REG_ADDR_W-1:0]      addrs_i [DEPTH],
  input  logic [D_BITS-1:0]          datas_i [DEPTH],
  input  logic [$clog2(DEPTH)-1:0]   head_i,
  input  logic [$clog2(DEPTH):0]     count_i,
  output logic                       hit_o,
  output logic [D_BITS-1:0]          data_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] idx;

  // Walk oldest to newest; later matches override, so the newest wins.
  always_comb begin
    hit_o  = 1'b0;
    data_o = '0;
    idx    = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = PTR_W'(head_i + PTR_W'(i));
      if ((CNT_W'(i) < count_i) && (addrs_i[idx] == src_i)) begin
        hit_o  = 1'b1;
        data_o = datas_i[idx];
      end
    end
  end

endmodule

// File: rtl/wb_write_queue.sv
// In-order register-file write queue with operand forwarding.
// Optional same-index write coalescing is enabled by defining WB_COALESCE_EN.
module wb_write_queue
  import wb_pkg::*;
#(
  parameter int unsigned D_BITS = 32,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                    clk,
  input  logic                    nrst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [REG_ADDR_W-1:0]   in_addr,
  input  logic [D_BITS-1:0]       in_data,
  input  logic                    drain_en,
  output logic                    rf_we,
  output logic [REG_ADDR_W-1:0]   rf_addr_w,
  output logic [D_BITS-1:0]       rf_data,
  input  logic [REG_ADDR_W-1:0]   fwd_src_op0,
  input  logic [REG_ADDR_W-1:0]   fwd_src_op1,
  output logic                    fwd_hit0,
  output logic [D_BITS-1:0]       fwd_data0,
  output logic                    fwd_hit1,
  output logic [D_BITS-1:0]       fwd_data1,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [REG_ADDR_W-1:0] addr_q [DEPTH];
  logic [D_BITS-1:0]     data_q [DEPTH];
  logic [PTR_W-1:0]      head_q, head_d, tail_q, tail_d, newest;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  non_empty, push, pop, alloc, coal_hit;
  logic                  hit0_c, hit1_c;

  assign non_empty = (count_q != '0);
  assign newest    = PTR_W'(tail_q - PTR_W'(1));
  assign pop       = rf_we;
  assign push      = in_valid && in_ready;
  assign count     = count_q;

`ifdef WB_COALESCE_EN
  // Merge into the newest entry unless it is the head leaving this cycle.
  assign coal_hit = non_empty && (addr_q[newest] == in_addr) &&
                    !(pop && (count_q == CNT_W'(1)));
  assign in_ready = nrst && ((count_q < CNT_W'(DEPTH)) || coal_hit);
`else
  assign coal_hit = 1'b0;
  assign in_ready = nrst && (count_q < CNT_W'(DEPTH));
`endif

  assign alloc     = push && !coal_hit;
  assign rf_we     = nrst && drain_en && non_empty;
  assign rf_addr_w = non_empty ? addr_q[head_q] : '0;
  assign rf_data   = non_empty ? data_q[head_q] : '0;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (pop)   head_d = PTR_W'(head_q + PTR_W'(1));
    if (alloc) tail_d = PTR_W'(tail_q + PTR_W'(1));
    count_d = CNT_W'(count_q + CNT_W'(alloc) - CNT_W'(pop));
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage; validity is defined purely by the head/count window.
  always_ff @(posedge clk) begin
    if (alloc) begin
      addr_q[tail_q] <= in_addr;
      data_q[tail_q] <= in_data;
    end else if (push) begin
      data_q[newest] <= in_data;
    end
  end

  wb_fwd_match #(.D_BITS(D_BITS), .DEPTH(DEPTH)) u_fwd0 (
    .src_i   (fwd_src_op0),
    .addrs_i (addr_q),
    .datas_i (data_q),
    .head_i  (head_q),
    .count_i (count_q),
    .hit_o   (hit0_c),
    .data_o  (fwd_data0)
  );

  wb_fwd_match #(.D_BITS(D_BITS), .DEPTH(DEPTH)) u_fwd1 (
    .src_i   (fwd_src_op1),
    .addrs_i (addr_q),
    .datas_i (data_q),
    .head_i  (head_q),
    .count_i (count_q),
    .hit_o   (hit1_c),
    .data_o  (fwd_data1)
  );

  assign fwd_hit0 = nrst && hit0_c;
  assign fwd_hit1 = nrst && hit1_c;

endmodule

// File: tb/tb_wb_write_queue.sv
// Directed self-checking bench for wb_write_queue (DEPTH=4, D_BITS=32).
module tb_wb_write_queue;

  logic        clk = 1'b0;
  logic        nrst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_addr;
  logic [31:0] in_data;
  logic        drain_en;
  logic        rf_we;
  logic [2:0]  rf_addr_w;
  logic [31:0] rf_data;
  logic [2:0]  fwd_src_op0, fwd_src_op1;
  logic        fwd_hit0, fwd_hit1;
  logic [31:0] fwd_data0, fwd_data1;
  logic [2:0]  count;

  int checks = 0;
  int errors = 0;

  wb_write_queue #(.D_BITS(32), .DEPTH(4)) dut (
    .clk(clk), .nrst(nrst), .in_valid(in_valid), .in_ready(in_ready),
    .in_addr(in_addr), .in_data(in_data), .drain_en(drain_en),
    .rf_we(rf_we), .rf_addr_w(rf_addr_w), .rf_data(rf_data),
    .fwd_src_op0(fwd_src_op0), .fwd_src_op1(fwd_src_op1),
    .fwd_hit0(fwd_hit0), .fwd_data0(fwd_data0),
    .fwd_hit1(fwd_hit1), .fwd_data1(fwd_data1), .count(count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    nrst = 1'b0; in_valid = 1'b0; in_addr = '0; in_data = '0;
    drain_en = 1'b1; fwd_src_op0 = 3'd0; fwd_src_op1 = 3'd0;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL rst_rf_we: got %b want 0", rf_we); end
    step(); step();
    drain_en = 1'b0; nrst = 1'b1;
    #1;
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL rst_count: got %0d want 0", count); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_ready_after: got %b want 1", in_ready); end
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL rst_we_after: got %b want 0", rf_we); end
    checks++; if ({fwd_hit0, fwd_hit1} !== 2'b00) begin errors++; $display("FAIL rst_hits: got %b want 00", {fwd_hit0, fwd_hit1}); end
  endtask

  task automatic test_single();
    fwd_src_op0 = 3'd3;
    in_valid = 1'b1; in_addr = 3'd3; in_data = 32'hDEADBEEF;
    #1;
    checks++; if (fwd_hit0 !== 1'b0) begin errors++; $display("FAIL single_incoming_not_fwd: got %b want 0", fwd_hit0); end
    step();
    in_valid = 1'b0;
    #1;
    checks++; if (count !== 3'd1) begin errors++; $display("FAIL single_count: got %0d want 1", count); end
    checks++; if (fwd_hit0 !== 1'b1 || fwd_data0 !== 32'hDEADBEEF) begin errors++; $display("FAIL single_fwd: got %b/%h want 1/deadbeef", fwd_hit0, fwd_data0); end
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL single_no_drain: got %b want 0", rf_we); end
    drain_en = 1'b1;
    #1;
    checks++; if (rf_we !== 1'b1 || rf_addr_w !== 3'd3 || rf_data !== 32'hDEADBEEF) begin errors++; $display("FAIL single_write: got %b/%0d/%h want 1/3/deadbeef", rf_we, rf_addr_w, rf_data); end
    step();
    checks++; if (count !== 3'd0 || rf_we !== 1'b0 || rf_addr_w !== 3'd0) begin errors++; $display("FAIL single_after: got cnt %0d we %b addr %0d want 0/0/0", count, rf_we, rf_addr_w); end
    drain_en = 1'b0;
  endtask

  task automatic test_fill();
    for (int a = 1; a <= 4; a++) begin
      in_valid = 1'b1; in_addr = 3'(a); in_data = 32'h100 + 32'(a);
      step();
    end
    in_addr = 3'd5; in_data = 32'h105;
    #1;
    checks++; if (count !== 3'd4 || in_ready !== 1'b0) begin errors++; $display("FAIL fill_full: got cnt %0d rdy %b want 4/0", count, in_ready); end
    step();
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL fill_refuse: got %0d want 4", count); end
    drain_en = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL fill_no_lookahead: got %b want 0", in_ready); end
    for (int a = 1; a <= 4; a++) begin
      checks++; if (rf_we !== 1'b1 || rf_addr_w !== 3'(a) || rf_data !== 32'h100 + 32'(a)) begin errors++; $display("FAIL fill_order%0d: got %b/%0d/%h want 1/%0d/%h", a, rf_we, rf_addr_w, rf_data, a, 32'h100 + 32'(a)); end
      step();
      in_valid = 1'b0;
    end
    checks++; if (count !== 3'd0 || rf_we !== 1'b0) begin errors++; $display("FAIL fill_empty: got cnt %0d we %b want 0/0", count, rf_we); end
    drain_en = 1'b0;
  endtask

  task automatic test_newest_wins();
    logic [2:0] exp_cnt;
    fwd_src_op1 = 3'd2;
    in_valid = 1'b1; in_addr = 3'd2; in_data = 32'h11; step();
    in_data = 32'h22; step();
    in_valid = 1'b0;
`ifdef WB_COALESCE_EN
    exp_cnt = 3'd1;
`else
    exp_cnt = 3'd2;
`endif
    checks++; if (count !== exp_cnt) begin errors++; $display("FAIL newest_count: got %0d want %0d", count, exp_cnt); end
    checks++; if (fwd_hit1 !== 1'b1 || fwd_data1 !== 32'h22) begin errors++; $display("FAIL newest_fwd: got %b/%h want 1/22", fwd_hit1, fwd_data1); end
    drain_en = 1'b1;
    #1;
    checks++; if (fwd_hit1 !== 1'b1) begin errors++; $display("FAIL newest_head_pop_hit: got %b want 1", fwd_hit1); end
    step();
`ifndef WB_COALESCE_EN
    checks++; if (fwd_hit1 !== 1'b1 || fwd_data1 !== 32'h22) begin errors++; $display("FAIL newest_after_pop1: got %b/%h want 1/22", fwd_hit1, fwd_data1); end
    step();
`endif
    checks++; if (fwd_hit1 !== 1'b0 || fwd_data1 !== 32'h0 || count !== 3'd0) begin errors++; $display("FAIL newest_drained: got %b/%h cnt %0d want 0/0/0", fwd_hit1, fwd_data1, count); end
    drain_en = 1'b0;
  endtask

  task automatic test_back_to_back();
    fwd_src_op0 = 3'd0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_addr = 3'(i); in_data = 32'h1000 + 32'(i);
      step();
    end
    checks++; if (fwd_hit0 !== 1'b1 || fwd_data0 !== 32'h1000) begin errors++; $display("FAIL b2b_reg0_fwd: got %b/%h want 1/1000", fwd_hit0, fwd_data0); end
    drain_en = 1'b1;
    for (int i = 2; i < 10; i++) begin
      in_addr = 3'(i % 8); in_data = 32'h1000 + 32'(i);
      #1;
      checks++; if (rf_we !== 1'b1 || rf_addr_w !== 3'((i - 2) % 8) || rf_data !== 32'h1000 + 32'(i - 2)) begin errors++; $display("FAIL b2b_pop%0d: got %b/%0d/%h want 1/%0d/%h", i - 2, rf_we, rf_addr_w, rf_data, (i - 2) % 8, 32'h1000 + 32'(i - 2)); end
      step();
      checks++; if (count !== 3'd2) begin errors++; $display("FAIL b2b_count%0d: got %0d want 2", i, count); end
    end
    in_valid = 1'b0;
    for (int i = 8; i < 10; i++) begin
      checks++; if (rf_we !== 1'b1 || rf_addr_w !== 3'(i % 8) || rf_data !== 32'h1000 + 32'(i)) begin errors++; $display("FAIL b2b_tail%0d: got %b/%0d/%h want 1/%0d/%h", i, rf_we, rf_addr_w, rf_data, i % 8, 32'h1000 + 32'(i)); end
      step();
    end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL b2b_empty: got %0d want 0", count); end
    drain_en = 1'b0;
  endtask

  task automatic test_reset_mid();
    fwd_src_op0 = 3'd5;
    for (int a = 5; a <= 7; a++) begin
      in_valid = 1'b1; in_addr = 3'(a); in_data = 32'h500 + 32'(a);
      step();
    end
    in_valid = 1'b0;
    checks++; if (count !== 3'd3) begin errors++; $display("FAIL mid_count3: got %0d want 3", count); end
    nrst = 1'b0; drain_en = 1'b1;
    #1;
    checks++; if (rf_we !== 1'b0 || in_ready !== 1'b0 || fwd_hit0 !== 1'b0) begin errors++; $display("FAIL mid_in_reset: got we %b rdy %b hit %b want 0/0/0", rf_we, in_ready, fwd_hit0); end
    step();
    nrst = 1'b1;
    #1;
    checks++; if (count !== 3'd0 || rf_we !== 1'b0 || fwd_hit0 !== 1'b0) begin errors++; $display("FAIL mid_after: got cnt %0d we %b hit %b want 0/0/0", count, rf_we, fwd_hit0); end
    step();
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL mid_no_write: got %b want 0", rf_we); end
    drain_en = 1'b0;
  endtask

`ifdef WB_COALESCE_EN
  task automatic test_coalesce();
    in_valid = 1'b1; in_addr = 3'd6; in_data = 32'hA; step();
    in_data = 32'hB; step();
    in_valid = 1'b0;
    checks++; if (count !== 3'd1) begin errors++; $display("FAIL coal_count: got %0d want 1", count); end
    drain_en = 1'b1;
    #1;
    checks++; if (rf_we !== 1'b1 || rf_addr_w !== 3'd6 || rf_data !== 32'hB) begin errors++; $display("FAIL coal_data: got %b/%0d/%h want 1/6/b", rf_we, rf_addr_w, rf_data); end
    step();
    drain_en = 1'b0;
    for (int a = 1; a <= 4; a++) begin
      in_valid = 1'b1; in_addr = 3'(a); in_data = 32'h40 + 32'(a);
      step();
    end
    in_addr = 3'd4; in_data = 32'h44;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL coal_full_ready: got %b want 1", in_ready); end
    step();
    in_valid = 1'b0;
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL coal_full_count: got %0d want 4", count); end
    drain_en = 1'b1;
    step(); step(); step();
    checks++; if (rf_addr_w !== 3'd4 || rf_data !== 32'h44) begin errors++; $display("FAIL coal_full_data: got %0d/%h want 4/44", rf_addr_w, rf_data); end
    step();
    drain_en = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_newest_wins();
    test_back_to_back();
    test_reset_mid();
`ifdef WB_COALESCE_EN
    test_coalesce();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
